mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between the instruction-fetch requester (imem) and the data-memory requester (dmem) of the pipelined datapath.
- Registered grant FSM: holds one requester on the RAM until RAM signals ACCESS, then releases.
- Data requests have priority. A streak counter prevents fetch starvation.
- Sits between the datapath/cache interface and the RAM model.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while iREN is pending before a fetch grant is forced (range 1..15).
- ADDR_W, 32: address and data width (word_t).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  high = instruction not yet served.
- iload  out  ADDR_W  instruction word; valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  write data.
- dwait  out  1  high = data access not yet served.
- dload  out  ADDR_W  read data; valid when dREN && !dwait.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  RAM status, ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- FSM states: IDLE, IGRANT, DGRANT. Reset → IDLE, streak=0.
- Outputs in IDLE (and during reset): ramREN=0, ramWEN=0, ramaddr=0, ramstore=0; iwait=iREN; dwait=dREN|dWEN; iload=dload=ramload, passed through.
- IDLE transitions, registered, taking effect next cycle:
  - If (dREN|dWEN) && !(iREN && streak==MAX_DSTREAK) → DGRANT.
  - Else if iREN → IGRANT.
  - Else stay.
- DGRANT outputs, combinational from inputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&&!dWEN. If both are set, the write wins and a read is not issued.
  - dwait=!(ramstate==ACCESS); iwait=iREN.
- IGRANT outputs: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0; iwait=!(ramstate==ACCESS); dwait=dREN|dWEN.
- Completion: ramstate==ACCESS in a grant state → wait low for exactly that cycle; next state IDLE.
- Streak update on completion:
  - DGRANT completion: streak = iREN ? sat(streak+1) : 0. Saturates at MAX_DSTREAK and never wraps.
  - IGRANT completion: streak=0.
- Latency: the request is sampled in IDLE at cycle N, the RAM is enabled at cycle N+1, and the earliest completion is cycle N+1 (0-latency RAM). There is always 1 IDLE cycle between grants.
- Requester drops its request mid-grant (DGRANT with !dREN&&!dWEN, or IGRANT with !iREN): abort, RAM enables low that cycle, next state IDLE, streak unchanged.
- BUSY or FREE in a grant state: hold the grant and keep the enables asserted.
- ERROR in a grant state: treated as BUSY, so the access is retried. The grant is held.
- Simultaneous iREN and data request in IDLE: data is granted unless streak==MAX_DSTREAK, in which case fetch is granted.
- Asynchronous reset mid-grant: immediately IDLE, enables low, streak=0. The in-flight access is discarded.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds the following outputs:
  - icount (32): completed fetches.
  - dcount (32): completed data accesses.
  - stallcount (32): cycles with any wait high.
- All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Add to cpu_types_pkg:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - arb_state_t enum (IDLE, IGRANT, DGRANT).
  - word_t, reused.
- Optional sub-module: arb_streak_ctr (saturating counter with inc/clear/sat outputs).
- Everything else is flat in mem_arbiter.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0040, RAM returning ACCESS immediately with ramload=0x2008_0001 → ramREN=1 and ramaddr=0x40 at cycle 1; iwait=0 and iload=0x2008_0001 at cycle 1; FSM in IDLE at cycle 2.
- iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD_BEEF) held together, RAM latency 2 → DGRANT first, with ramWEN=1 and ramstore=0xDEAD_BEEF for 3 cycles. dwait falls on the ACCESS cycle. IGRANT follows after one IDLE cycle.
- iREN and dREN both held continuously, MAX_DSTREAK=4, 0-latency RAM → grant order D,D,D,D,I,D,D,D,D,I. The streak returns to 0 after each I.
- dREN dropped in cycle 2 of a 3-cycle RAM latency → ramREN=0 in that cycle; next state IDLE; dwait=0 since dREN=0; no ACCESS consumed.
- ramstate=ERROR for 2 cycles then ACCESS during IGRANT → ramREN held high for 3 cycles, iwait high for 2 cycles then low.
- nRST pulsed low mid-DGRANT → same cycle ramWEN=ramREN=0 and ramaddr=0; after release, with MEM_ARB_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake status and memory arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int STREAK_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of back-to-back data grants made while a fetch was waiting.
// Latency: count updates on the clock edge after inc/clr; sat is combinational from count.
// Backpressure: none; clr has priority over inc, and inc is ignored once saturated.
module arb_streak_ctr
  import cpu_types_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                inc,
  input  logic                clr,
  output logic [STREAK_W-1:0] count,
  output logic                sat
);

  assign sat = (count == STREAK_W'(MAX));

  // Count up to MAX and park there; clear wins over increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins unless fetch has starved MAX_DSTREAK grants.
// Latency: request sampled in IDLE at N, RAM enabled at N+1, earliest completion N+1; one IDLE cycle between grants.
// Backpressure: iwait/dwait stay high until RAM reports ACCESS; MEM_ARB_STATS_EN adds icount/dcount/stallcount outputs.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcount
`endif
);

  arb_state_t          state;
  ramstate_t           ram_st;
  logic                dreq;
  logic                access;
  logic                d_done;
  logic                i_done;
  logic                streak_inc;
  logic                streak_clr;
  logic                streak_sat;
  logic [STREAK_W-1:0] streak;

  assign ram_st = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign access = (ram_st == ACCESS);

  // A grant completes only if its requester is still asking; a dropped request is an abort.
  assign d_done = (state == DGRANT) && dreq && access;
  assign i_done = (state == IGRANT) && iREN && access;

  // Streak grows only while a fetch is actually being held off.
  assign streak_inc = d_done && iREN;
  assign streak_clr = (d_done && !iREN) || i_done;

  arb_streak_ctr #(
    .MAX (MAX_DSTREAK)
  ) u_streak (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (streak_inc),
    .clr   (streak_clr),
    .count (streak),
    .sat   (streak_sat)
  );

  // Read data is shared by both requesters; each only trusts it when its wait is low.
  assign iload = ramload;
  assign dload = ramload;

  // Route the granted requester onto the RAM and generate both wait signals.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        dwait    = dreq && !access;
      end
      IGRANT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
        iwait    = iREN && !access;
      end
      default: begin
      end
    endcase
  end

  // Grant FSM: pick a requester from IDLE, hold it through BUSY/FREE/ERROR, release on ACCESS or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !(iREN && streak_sat)) begin
            state <= DGRANT;
          end else if (iREN) begin
            state <= IGRANT;
          end
        end
        DGRANT: begin
          if (!dreq || access) begin
            state <= IDLE;
          end
        end
        IGRANT: begin
          if (!iREN || access) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Free-running performance counters; they wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (i_done) begin
        icount <= icount + 32'd1;
      end
      if (d_done) begin
        dcount <= dcount + 32'd1;
      end
      if (iwait || dwait) begin
        stallcount <= stallcount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write/fetch contention, starvation guard, abort, ERROR retry, reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: RAM status is scripted per cycle to model latency and errors.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount;
  logic [31:0] dcount;
  logic [31:0] stallcount;
`endif

  int vectors;
  int miscompares;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  mem_arbiter #(
    .MAX_DSTREAK (4),
    .ADDR_W      (32)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = RS_FREE;

    // Reset state; a fetch already pending is reported as waiting.
    tick();
    tick();
    iREN     = 1'b1;
    iaddr    = 32'h0000_0040;
    ramload  = 32'h2008_0001;
    ramstate = RS_ACCESS;
    #1;
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd0);
    nRST = 1'b1;

    // Single fetch against a zero-latency RAM.
    tick();
    chk("f1_ramREN", {31'd0, ramREN}, 32'd1);
    chk("f1_ramaddr", ramaddr, 32'h0000_0040);
    chk("f1_iwait", {31'd0, iwait}, 32'd0);
    chk("f1_iload", iload, 32'h2008_0001);
    tick();
    iREN = 1'b0;
    #1;
    chk("f2_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("f2_idle_ramaddr", ramaddr, 32'd0);

    // Write and fetch together; write first with RAM latency 2, then the fetch.
    tick();
    iREN     = 1'b1;
    iaddr    = 32'h0000_0080;
    dWEN     = 1'b1;
    daddr    = 32'h0000_0100;
    dstore   = 32'hDEAD_BEEF;
    ramstate = RS_BUSY;
    #1;
    chk("wf0_dwait", {31'd0, dwait}, 32'd1);
    chk("wf0_ramWEN", {31'd0, ramWEN}, 32'd0);
    tick();
    chk("wf1_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("wf1_ramREN", {31'd0, ramREN}, 32'd0);
    chk("wf1_ramaddr", ramaddr, 32'h0000_0100);
    chk("wf1_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("wf1_dwait", {31'd0, dwait}, 32'd1);
    chk("wf1_iwait", {31'd0, iwait}, 32'd1);
    tick();
    chk("wf2_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("wf2_dwait", {31'd0, dwait}, 32'd1);
    tick();
    ramstate = RS_ACCESS;
    #1;
    chk("wf3_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("wf3_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("wf3_dwait", {31'd0, dwait}, 32'd0);
    tick();
    dWEN     = 1'b0;
    ramstate = RS_BUSY;
    #1;
    chk("wf4_idle_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("wf4_idle_iwait", {31'd0, iwait}, 32'd1);
    tick();
    ramstate = RS_ACCESS;
    #1;
    chk("wf5_ig_ramREN", {31'd0, ramREN}, 32'd1);
    chk("wf5_ig_ramaddr", ramaddr, 32'h0000_0080);
    chk("wf5_ig_iwait", {31'd0, iwait}, 32'd0);
    tick();
    iREN = 1'b0;
    #1;
    chk("wf6_idle_ramREN", {31'd0, ramREN}, 32'd0);

    // Continuous contention: expected grant order D,D,D,D,I,D,D,D,D,I.
    iREN     = 1'b1;
    iaddr    = 32'h0000_0200;
    dREN     = 1'b1;
    daddr    = 32'h0000_0300;
    ramstate = RS_ACCESS;
    for (int g = 0; g < 10; g++) begin
      tick();
      chk($sformatf("streak_g%0d_ramaddr", g), ramaddr,
          ((g == 4) || (g == 9)) ? 32'h0000_0200 : 32'h0000_0300);
      chk($sformatf("streak_g%0d_ramREN", g), {31'd0, ramREN}, 32'd1);
      tick();
      if (g == 9) begin
        iREN = 1'b0;
        dREN = 1'b0;
      end
    end

    // Data read abandoned in the second cycle of a slow access.
    dREN     = 1'b1;
    daddr    = 32'h0000_0400;
    ramstate = RS_BUSY;
    #1;
    chk("ab0_dwait", {31'd0, dwait}, 32'd1);
    tick();
    chk("ab1_ramREN", {31'd0, ramREN}, 32'd1);
    chk("ab1_ramaddr", ramaddr, 32'h0000_0400);
    tick();
    dREN = 1'b0;
    #1;
    chk("ab2_ramREN", {31'd0, ramREN}, 32'd0);
    chk("ab2_dwait", {31'd0, dwait}, 32'd0);
    tick();
    chk("ab3_idle_ramaddr", ramaddr, 32'd0);
    chk("ab3_idle_ramREN", {31'd0, ramREN}, 32'd0);

    // ERROR twice during a fetch, then ACCESS: the fetch is retried and held.
    iREN     = 1'b1;
    iaddr    = 32'h0000_0500;
    ramstate = RS_ERROR;
    tick();
    chk("er1_ramREN", {31'd0, ramREN}, 32'd1);
    chk("er1_iwait", {31'd0, iwait}, 32'd1);
    tick();
    chk("er2_ramREN", {31'd0, ramREN}, 32'd1);
    chk("er2_iwait", {31'd0, iwait}, 32'd1);
    tick();
    ramstate = RS_ACCESS;
    #1;
    chk("er3_ramREN", {31'd0, ramREN}, 32'd1);
    chk("er3_iwait", {31'd0, iwait}, 32'd0);
    tick();
    iREN = 1'b0;
    #1;
    chk("er4_idle_ramREN", {31'd0, ramREN}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("stats_icount", icount, 32'd5);
    chk("stats_dcount", dcount, 32'd9);
`endif

    // Asynchronous reset in the middle of a data write.
    dWEN     = 1'b1;
    daddr    = 32'h0000_0600;
    dstore   = 32'h0000_1234;
    ramstate = RS_BUSY;
    tick();
    chk("rs1_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("rs1_ramaddr", ramaddr, 32'h0000_0600);
    #1;
    nRST = 1'b0;
    #1;
    chk("rs2_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rs2_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rs2_ramaddr", ramaddr, 32'd0);
    chk("rs2_ramstore", ramstore, 32'd0);
    dWEN = 1'b0;
    #1;
    nRST = 1'b1;
    tick();
    chk("rs3_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rs3_ramaddr", ramaddr, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("rs3_icount", icount, 32'd0);
    chk("rs3_dcount", dcount, 32'd0);
    chk("rs3_stallcount", stallcount, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
